// File: rtl/uart_pkg.sv
// uart_pkg: shared types, register map and status bit positions for the MIO UART.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;
  localparam int ST_EMPTY = 8;
  localparam int ST_FULL = 9;
  localparam int ST_BUSY = 10;
  localparam int ST_OVF = 11;
  localparam int ST_IRQEN = 12;
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with pointer-MSB full/empty detection; push refused when full.
module io_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     RSTN,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign count = wp - rp;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/mio_uart_tx.sv
// mio_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO, status word and drain interrupt.
module mio_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD = 115200,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        tx_busy,
  output logic        irq
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DIVM = CW'(DIV - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift, dout;
  logic [AW:0] count;
  logic ovf, irq_en, push, pop, full, empty, tick, wr_data, wr_ctrl;
  assign wr_data = we & (addr == REG_TXDATA);
  assign wr_ctrl = we & (addr == REG_CTRL);
  assign push = wr_data;
  assign tick = cnt == '0;
  // Pop either from idle or exactly at the end of a stop bit so frames chain without a gap.
  assign pop = ~empty & ((state == IDLE) | ((state == STOP) & tick));
  assign irq = irq_en & empty & ~tx_busy;
  io_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .RSTN(RSTN), .push(push), .pop(pop), .din(wdata[7:0]),
    .dout(dout), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      ovf <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      ovf <= (wr_data & full) | (ovf & ~(wr_ctrl & wdata[1]));
      if (wr_ctrl) irq_en <= wdata[0];
    end
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      state <= IDLE;
      txd <= 1'b1;
      tx_busy <= 1'b0;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE:
          if (pop) begin
            shift <= dout;
            cnt <= DIVM;
            txd <= 1'b0;
            tx_busy <= 1'b1;
            state <= START;
          end
        START:
          if (tick) begin
            cnt <= DIVM;
            idx <= '0;
            txd <= shift[0];
            state <= DATA;
          end else cnt <= cnt - 1'b1;
        DATA:
          if (tick) begin
            cnt <= DIVM;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              txd <= 1'b1;
              state <= STOP;
            end else begin
              shift <= shift >> 1;
              txd <= shift[1];
            end
          end else cnt <= cnt - 1'b1;
        STOP:
          if (tick) begin
            if (pop) begin
              shift <= dout;
              cnt <= DIVM;
              txd <= 1'b0;
              state <= START;
            end else begin
              tx_busy <= 1'b0;
              state <= IDLE;
            end
          end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  always_comb begin
    rdata = '0;
    rdata[AW:0] = count;
    rdata[ST_EMPTY] = empty;
    rdata[ST_FULL] = full;
    rdata[ST_BUSY] = tx_busy;
    rdata[ST_OVF] = ovf;
    rdata[ST_IRQEN] = irq_en;
  end
endmodule

// File: tb/tb_mio_uart_tx.sv
// tb_mio_uart_tx: frame-timeline reference model checked every cycle, plus literal spot checks.
module tb_mio_uart_tx;
  localparam int DIV = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * DIV;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic we = 1'b0, addr = 1'b0, we2 = 1'b0, addr2 = 1'b0;
  logic [31:0] wdata = '0, wdata2 = '0, rdata, rdata2;
  logic txd, tx_busy, irq, txd2, busy2, irq2;
  always #5 clk = ~clk;
  mio_uart_tx #(.CLK_HZ(400), .BAUD(100), .DEPTH(DEPTH)) dut (
    .clk(clk), .RSTN(rstn), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .txd(txd), .tx_busy(tx_busy), .irq(irq)
  );
  mio_uart_tx #(.CLK_HZ(100000000), .BAUD(115200), .DEPTH(DEPTH)) dut_def (
    .clk(clk), .RSTN(rstn), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .txd(txd2), .tx_busy(busy2), .irq(irq2)
  );
  int tests = 0, fails = 0;
  // Model: a byte queue plus the position inside the frame currently on the line.
  logic [7:0] q[$];
  logic [7:0] cur = '0, nb;
  int pos = 0;
  bit active = 0, m_ovf = 0, m_irq_en = 0, pop_now, was_full;
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      q.delete();
      active = 0;
      pos = 0;
      m_ovf = 0;
      m_irq_en = 0;
    end else begin
      pop_now = q.size() != 0 && (!active || pos == FRAME - 1);
      was_full = q.size() == DEPTH;
      if (pop_now) nb = q.pop_front();
      if (active) pos = pos + 1;
      if (pos == FRAME) active = 0;
      if (pop_now) begin
        active = 1;
        pos = 0;
        cur = nb;
      end
      if (we && !addr) begin
        if (was_full) m_ovf = 1;
        else q.push_back(wdata[7:0]);
      end
      if (we && addr) begin
        m_irq_en = wdata[0];
        if (wdata[1]) m_ovf = 0;
      end
    end
  end
  function automatic logic m_txd();
    int b;
    if (!active) return 1'b1;
    b = pos / DIV;
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : cur[b-1];
  endfunction
  function automatic logic [31:0] m_rdata();
    logic [31:0] r;
    r = 32'(q.size());
    r[8] = q.size() == 0;
    r[9] = q.size() == DEPTH;
    r[10] = active;
    r[11] = m_ovf;
    r[12] = m_irq_en;
    return r;
  endfunction
  int req_n = 0, req_sig = 0;
  logic [31:0] req_mask = '0, req_exp = '0, req_act = '0;
  string req_name = "";
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", n, a, e, $time);
    end
  endtask
  initial begin
    int seen;
    logic [31:0] v;
    seen = 0;
    forever begin
      @(negedge clk);
      check("model_txd", {31'b0, txd}, {31'b0, m_txd()});
      check("model_busy", {31'b0, tx_busy}, {31'b0, active});
      check("model_irq", {31'b0, irq}, {31'b0, m_irq_en && q.size() == 0 && !active});
      check("model_rdata", rdata, m_rdata());
      if (req_n != seen) begin
        seen = req_n;
        v = req_sig == 0 ? {31'b0, txd} : req_sig == 1 ? {31'b0, tx_busy} :
            req_sig == 2 ? {31'b0, irq} : req_sig == 3 ? rdata : req_act;
        check(req_name, v & req_mask, req_exp);
      end
    end
  end
  task automatic req(input string n, input int sig, input logic [31:0] mask,
                     input logic [31:0] e, input logic [31:0] a = '0);
    req_name = n;
    req_sig = sig;
    req_mask = mask;
    req_exp = e;
    req_act = a;
    req_n++;
    @(negedge clk);
    #1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic a, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    step();
    we = 1'b0;
  endtask
  initial begin
    logic [9:0] pat;
    int n, w, f;
    repeat (5) step();
    rstn = 1'b1;
    req("reset_rdata", 3, '1, 32'h100);
    req("reset_txd", 0, 1, 1);
    req("reset_irq", 2, 1, 0);
    wr(0, 32'h55);
    req("count_after_write", 3, 32'h1f, 1);
    pat = 10'b1010101010;
    for (int k = 0; k < 40; k++) req("frame_55", 0, 1, {31'b0, pat[k/4]});
    req("busy_fall_n41", 1, 1, 0);
    we = 1'b1;
    addr = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wdata = 32'(i);
      step();
    end
    we = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!tx_busy) break;
      n++;
    end
    #1;
    // 17 gapless frames keep busy high from edge 1 to edge 681 of the burst; sampling starts after edge 17.
    req("burst_busy_span", 4, '1, 17 * 40 - 16, 32'(n));
    req("ovf_set", 3, 32'h800, 32'h800);
    wr(1, 32'h2);
    req("ovf_clear", 3, 32'h800, 0);
    wr(1, 32'h1);
    req("irq_enable", 2, 1, 1);
    wr(0, 32'h3c);
    for (int k = 0; k < 41; k++) req("irq_low_in_frame", 2, 1, 0);
    req("irq_after_stop", 2, 1, 1);
    wr(0, 32'ha1);
    wr(0, 32'hb2);
    wr(0, 32'hc3);
    req("two_queued", 3, 32'h1f, 2);
    repeat (16) step();
    rstn = 1'b0;
    req("reset_txd_async", 0, 1, 1);
    req("reset_rdata_mid", 3, '1, 32'h100);
    rstn = 1'b1;
    req("post_reset_count", 3, 32'h1f, 0);
    for (int k = 0; k < 100; k++) req("post_reset_quiet", 0, 1, 1);
    we2 = 1'b1;
    wdata2 = 32'ha3;
    step();
    we2 = 1'b0;
    n = 0;
    while (n < 100 && txd2) begin
      @(negedge clk);
      n++;
    end
    w = 0;
    while (w < 2000 && !txd2) begin
      w++;
      @(negedge clk);
    end
    f = w;
    while (f < 20000 && busy2) begin
      f++;
      @(negedge clk);
    end
    #1;
    req("default_start_width", 4, '1, 868, 32'(w));
    req("default_frame_len", 4, '1, 8680, 32'(f));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
